// File: rtl/riscv_mc_control.sv
// ----------------------------------------------------------------------------
// riscv_mc_control
//
// Multicycle RISC-V control unit. A Moore FSM walks each instruction through
// Fetch / Decode / Execute / Memory / Writeback and drives every datapath
// select and write-enable. It also counts retired instructions and pulses
// Illegal when Decode sees an unsupported opcode.
//
// Parameters:
//   EN_JAL  1 enables jal (opcode 1101111); 0 makes that opcode illegal
//   CNT_W   width of the retired-instruction counter (wraps at 2^CNT_W)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   op          Instr[6:0] from the instruction register
//   funct3      Instr[14:12]
//   funct7b5    Instr[30]
//   Zero        ALU zero flag
//   PCWrite     PC load enable
//   AdrSrc      memory address select (0=PC, 1=ALUOut)
//   MemWrite    data memory write enable
//   IRWrite     instruction register load enable
//   RegWrite    register file write enable
//   ResultSrc   00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUSrcA     00=PC, 01=OldPC, 10=RD1
//   ALUSrcB     00=RD2, 01=ImmExt, 10=constant 4
//   ImmSrc      00=I, 01=S, 10=B, 11=J
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   Illegal     one-cycle pulse in Decode for an unsupported opcode
//   InstRet     retired-instruction count
//   State       current FSM state code (debug)
// ----------------------------------------------------------------------------
module riscv_mc_control #(
  parameter int EN_JAL = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstRet,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       pc_update;
  logic       branch;
  logic       retire;
  logic [1:0] alu_op;
  logic       jal_ok;

  assign jal_ok = (EN_JAL != 0) && (op == OP_JAL);

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    Illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        IRWrite   = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYP) begin
          state_d = S_EXECUTER;
        end else if (op == OP_ITYP) begin
          state_d = S_EXECUTEI;
        end else if (op == OP_BEQ) begin
          state_d = S_BEQ;
        end else if (jal_ok) begin
          state_d = S_JAL;
        end else begin
          // Unsupported opcode: drop the instruction without retiring it
          state_d = S_FETCH;
          Illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        state_d   = S_FETCH;
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        state_d  = S_FETCH;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        state_d  = S_FETCH;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        state_d = S_FETCH;
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  assign PCWrite = pc_update | (branch & Zero);

  // Immediate format follows the opcode alone, independent of state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; subtract only for R-type with funct7b5 set (op[5] separates R from I)
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign InstRet = instret_q;
  assign State   = state_q;

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multicycle control unit sitting directly upstream of the RISC-V datapath.
- Decodes opcode/funct fields from the instruction register and sequences Fetch/Decode/Execute/Memory/Writeback through a Moore FSM.
- Drives every datapath select and write-enable: ImmSrc, ALUSrc, ResultSrc, ALUControl, RegWrite, MemWrite, PCWrite and IRWrite.
- Also counts retired instructions and flags unsupported opcodes.

Parameters:
EN_JAL  1  when 0, opcode 1101111 is treated as illegal
CNT_W  32  width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
op  in  7  Instr[6:0] from instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register load enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register load enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
Illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
InstRet  out  CNT_W  retired-instruction count
State  out  4  current state, for debug

Behaviour:
- Reset: rst=0 asynchronously forces State=FETCH(0) and InstRet=0. All other outputs are combinational functions of State and the inputs. During reset they therefore show the FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11-15 go to FETCH on the next edge.
- Transitions, one per rising edge:
  - FETCH -> DECODE.
  - DECODE branches on op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 with EN_JAL=1 -> JAL
    - anything else -> FETCH, with Illegal=1 during that DECODE cycle
  - MEMADR -> MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - ALUWB -> FETCH.
  - BEQ -> FETCH.
- Per-state outputs (unlisted outputs are 0; ALUOp is internal):
  - FETCH: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc depends on op only, in every state:
  - lw, I-ALU -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - otherwise -> 00
- ALUControl:
  - ALUOp 00 -> 000.
  - ALUOp 01 -> 001.
  - ALUOp 10, decoded on funct3:
    - 000 -> 001 if {op[5],funct7b5}=11, else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000
- Latencies (rising edges from FETCH back to FETCH):
  - lw: 5
  - sw, R-type, I-ALU, jal: 4
  - beq: 3
  - illegal: 2
- InstRet: increments by 1 on the edge leaving MEMWB, MEMWRITE, ALUWB or BEQ; wraps at 2^CNT_W. It is not incremented for an illegal opcode.
- Reset mid-instruction: the FSM aborts to FETCH immediately and no further write-enables are asserted other than the FETCH values.

Test Plan:
- Release rst, op=0000011 (lw) -> state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. InstRet=1 after the 5th edge.
- op=0100011 (sw) -> states 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in state 5. ImmSrc=01 throughout.
- op=0110011, funct3=000, funct7b5=1 -> EXECUTER shows ALUControl=001. With funct7b5=0 -> 000. With funct3=010 -> 101.
- op=1100011 -> BEQ. Zero=1 gives PCWrite=1 in BEQ; Zero=0 gives PCWrite=0. Both cases return to FETCH and increment InstRet.
- op=1111111 -> Illegal=1 for exactly the DECODE cycle, then FETCH, InstRet unchanged. Repeat with op=1101111 and EN_JAL=0 -> same result.
- Assert rst=0 asynchronously mid-MEMWRITE -> State=0 and MemWrite=0 before the next clock edge. InstRet=0.
